// File: rtl/query_patch_pkg.sv
// Shared constants and FSM state encoding for the query patch loader.
// Default geometry is one 26x19 frame of 5-sample, 11-bit patches.
package query_patch_pkg;

  localparam int DEF_DATA_WIDTH  = 11;
  localparam int DEF_PATCH_SIZE  = 5;
  localparam int DEF_ADDR_WIDTH  = 9;
  localparam int DEF_NUM_PATCHES = 494;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/query_patch_loader_if.sv
// Control, sample stream and patch RAM write port of the loader.
// The slave side is the loader itself; the master side feeds it.
interface query_patch_loader_if
  import query_patch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PATCH_SIZE = DEF_PATCH_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                             start;
  logic                             clear;
  logic                             in_valid;
  logic [DATA_WIDTH-1:0]            in_data;
  logic                             in_ready;
  logic                             csb0;
  logic                             web0;
  logic [ADDR_WIDTH-1:0]            addr0;
  logic [DATA_WIDTH*PATCH_SIZE-1:0] wpatch0;
  logic                             busy;
  logic                             done;
  logic [ADDR_WIDTH-1:0]            patch_count;

  modport master (
    output start, clear, in_valid, in_data,
    input  in_ready, csb0, web0, addr0, wpatch0,
    input  busy, done, patch_count
  );

  modport slave (
    input  start, clear, in_valid, in_data,
    output in_ready, csb0, web0, addr0, wpatch0,
    output busy, done, patch_count
  );

endinterface

// File: rtl/query_patch_loader.sv
// Packs a stream of samples into patches and writes each patch to a
// single-port RAM, one patch per address, for a whole frame.
module query_patch_loader
  import query_patch_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int PATCH_SIZE  = DEF_PATCH_SIZE,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_PATCHES = DEF_NUM_PATCHES
) (
  input logic                 clk,
  input logic                 rst,
  query_patch_loader_if.slave bus
);

  localparam int IW = idx_bits(PATCH_SIZE);
  localparam int PW = DATA_WIDTH * PATCH_SIZE;
  localparam logic [IW-1:0] LAST_IDX = IW'(PATCH_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PATCH =
    ADDR_WIDTH'(NUM_PATCHES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [IW-1:0]         idx;
  logic [PW-1:0]         asm_q;
  logic [PW-1:0]         patch_nxt;
  logic [ADDR_WIDTH-1:0] count;
  logic                  csb_q;
  logic                  web_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PW-1:0]         wdata_q;
  logic                  accept;
  logic                  last_sample;
  logic                  last_patch;

  assign accept      = (state == COLLECT) && bus.in_valid;
  assign last_sample = accept && (idx == LAST_IDX);
  assign last_patch  = (count == LAST_PATCH);

  assign bus.in_ready    = (state == COLLECT);
  assign bus.busy        = (state == COLLECT) || (state == WRITE);
  assign bus.done        = (state == DONE);
  assign bus.csb0        = csb_q;
  assign bus.web0        = web_q;
  assign bus.addr0       = addr_q;
  assign bus.wpatch0     = wdata_q;
  assign bus.patch_count = count;

  // Drop the incoming sample into its slot of the patch being built.
  always_comb begin
    patch_nxt = asm_q;
    for (int k = 0; k < PATCH_SIZE; k++) begin
      if (idx == IW'(k))
        patch_nxt[k*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
    end
  end

  // Next state; clear overrides everything, including start.
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start) state_nxt = COLLECT;
        COLLECT: if (last_sample) state_nxt = WRITE;
        WRITE:   state_nxt = last_patch ? DONE : COLLECT;
        DONE:    if (bus.start) state_nxt = COLLECT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Assembly, counters and the registered RAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      asm_q   <= '0;
      count   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      csb_q <= 1'b1;
      web_q <= 1'b1;
      if (bus.clear) begin
        idx   <= '0;
        asm_q <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.start) begin
              idx   <= '0;
              count <= '0;
              asm_q <= '0;
            end
          end
          COLLECT: begin
            if (last_sample) begin
              idx     <= '0;
              asm_q   <= '0;
              wdata_q <= patch_nxt;
              addr_q  <= count;
              csb_q   <= 1'b0;
              web_q   <= 1'b0;
            end else if (accept) begin
              idx   <= idx + 1'b1;
              asm_q <= patch_nxt;
            end
          end
          WRITE: count <= count + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_query_patch_loader.sv
// Directed checks of the query patch loader: single patch, start
// ignored mid-frame, clear, stalls, full frame, collision, reset.
module tb_query_patch_loader;
  import query_patch_pkg::*;

  localparam int DW = 11;
  localparam int PS = 5;
  localparam int AW = 9;
  localparam int NP = 494;
  localparam int PW = DW * PS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [AW-1:0] wr_addr[$];
  logic [PW-1:0] wr_data[$];
  int            wr_cyc[$];

  query_patch_loader_if bus ();

  query_patch_loader dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.csb0 === 1'b0) begin
      wr_addr.push_back(bus.addr0);
      wr_data.push_back(bus.wpatch0);
      wr_cyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] samp(input int p, input int k);
    return DW'((p * PS + k + 1) % 2048);
  endfunction

  function automatic logic [PW-1:0] exp_patch(input int p);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < PS; k++) r[k*DW +: DW] = samp(p, k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v, input int stall_pct);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    while (!acc) begin
      if (stall_pct > 0 && $urandom_range(99) < stall_pct)
        bus.in_valid = 1'b0;
      else
        bus.in_valid = 1'b1;
      bus.in_data = v;
      acc = bus.in_valid && bus.in_ready;
      tick();
      guard++;
      if (!acc && guard > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got no accept want accept of %0d", v);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic feed(input int p0, input int np, input int stall_pct);
    for (int p = p0; p < p0 + np; p++)
      for (int k = 0; k < PS; k++) send(samp(p, k), stall_pct);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks += 8;
    if (bus.csb0 !== 1'b1) begin errors++;
      $display("FAIL reset_csb0 got %b want 1", bus.csb0); end
    if (bus.web0 !== 1'b1) begin errors++;
      $display("FAIL reset_web0 got %b want 1", bus.web0); end
    if (bus.addr0 !== '0) begin errors++;
      $display("FAIL reset_addr0 got %0d want 0", bus.addr0); end
    if (bus.wpatch0 !== '0) begin errors++;
      $display("FAIL reset_wpatch0 got %h want 0", bus.wpatch0); end
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    if (bus.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.patch_count !== '0) begin errors++;
      $display("FAIL reset_count got %0d want 0", bus.patch_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_patch();
    clear_q();
    pulse_start();
    checks += 2;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL single_collect got busy=%b rdy=%b want 1 1",
               bus.busy, bus.in_ready); end
    if (bus.done !== 1'b0) begin errors++;
      $display("FAIL single_done got %b want 0", bus.done); end
    feed(0, 1, 0);
    checks += 2;
    if (bus.csb0 !== 1'b0 || bus.web0 !== 1'b0) begin errors++;
      $display("FAIL single_we got csb=%b web=%b want 0 0",
               bus.csb0, bus.web0); end
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL single_wr_rdy got %b want 0", bus.in_ready); end
    tick();
    tick();
    checks += 4;
    if (wr_addr.size() != 1) begin errors++;
      $display("FAIL single_nwr got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() > 0 && wr_addr[0] !== 9'd0) begin errors++;
      $display("FAIL single_addr got %0d want 0", wr_addr[0]); end
    if (wr_data.size() > 0 &&
        wr_data[0] !== {11'd5, 11'd4, 11'd3, 11'd2, 11'd1}) begin
      errors++;
      $display("FAIL single_data got %h want %h", wr_data[0],
               {11'd5, 11'd4, 11'd3, 11'd2, 11'd1}); end
    if (bus.patch_count !== 9'd1) begin errors++;
      $display("FAIL single_count got %0d want 1", bus.patch_count); end
  endtask

  task automatic test_start_ignored();
    clear_q();
    send(samp(1, 0), 0);
    send(samp(1, 1), 0);
    pulse_start();
    for (int k = 2; k < PS; k++) send(samp(1, k), 0);
    tick();
    checks += 3;
    if (wr_addr.size() != 1) begin errors++;
      $display("FAIL ign_nwr got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() > 0 && wr_addr[0] !== 9'd1) begin errors++;
      $display("FAIL ign_addr got %0d want 1", wr_addr[0]); end
    if (wr_data.size() > 0 && wr_data[0] !== exp_patch(1)) begin
      errors++;
      $display("FAIL ign_data got %h want %h", wr_data[0],
               exp_patch(1)); end
  endtask

  task automatic test_clear();
    clear_q();
    for (int k = 0; k < 3; k++) send(samp(2, k), 0);
    pulse_clear();
    checks += 2;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL clear_idle got rdy=%b busy=%b want 0 0",
               bus.in_ready, bus.busy); end
    if (bus.done !== 1'b0) begin errors++;
      $display("FAIL clear_done got %b want 0", bus.done); end
    bus.in_valid = 1'b1;
    bus.in_data = samp(2, 3);
    repeat (8) tick();
    bus.in_valid = 1'b0;
    checks++;
    if (wr_addr.size() != 0) begin errors++;
      $display("FAIL clear_nowr got %0d want 0", wr_addr.size()); end
    pulse_start();
    feed(0, 1, 0);
    tick();
    checks += 2;
    if (wr_addr.size() != 1 || wr_addr[0] !== 9'd0) begin errors++;
      $display("FAIL clear_restart_addr got n=%0d want one at 0",
               wr_addr.size()); end
    if (wr_data.size() > 0 && wr_data[0] !== exp_patch(0)) begin
      errors++;
      $display("FAIL clear_restart_data got %h want %h", wr_data[0],
               exp_patch(0)); end
    pulse_clear();
  endtask

  task automatic test_stall();
    int bad;
    clear_q();
    pulse_start();
    feed(0, 4, 40);
    repeat (3) tick();
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp_patch(i)) bad++;
    checks += 3;
    if (wr_addr.size() != 4) begin errors++;
      $display("FAIL stall_nwr got %0d want 4", wr_addr.size()); end
    if (bad != 0) begin errors++;
      $display("FAIL stall_data got %0d bad writes want 0", bad); end
    if (bus.patch_count !== 9'd4) begin errors++;
      $display("FAIL stall_count got %0d want 4", bus.patch_count); end
    pulse_clear();
  endtask

  task automatic test_full_frame();
    int bad_a, bad_d, bad_g, guard;
    clear_q();
    pulse_start();
    feed(0, NP, 0);
    guard = 0;
    while (bus.done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    bad_a = 0;
    bad_d = 0;
    bad_g = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== AW'(i)) bad_a++;
      if (wr_data[i] !== exp_patch(i)) bad_d++;
      if (i > 0 && wr_cyc[i] - wr_cyc[i-1] != PS + 1) bad_g++;
    end
    checks += 5;
    if (bus.done !== 1'b1) begin errors++;
      $display("FAIL frame_done got %b want 1", bus.done); end
    if (wr_addr.size() != NP) begin errors++;
      $display("FAIL frame_nwr got %0d want %0d", wr_addr.size(), NP); end
    if (bad_a != 0 || bad_d != 0) begin errors++;
      $display("FAIL frame_content got %0d bad addr %0d bad data want 0",
               bad_a, bad_d); end
    if (bad_g != 0) begin errors++;
      $display("FAIL frame_rate got %0d bad gaps want 0", bad_g); end
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL frame_idle got rdy=%b busy=%b want 0 0",
               bus.in_ready, bus.busy); end
    repeat (5) tick();
    checks += 2;
    if (bus.done !== 1'b1) begin errors++;
      $display("FAIL frame_hold got %b want 1", bus.done); end
    if (bus.patch_count !== 9'd494) begin errors++;
      $display("FAIL frame_count got %0d want 494", bus.patch_count); end
  endtask

  task automatic test_collision();
    bus.start = 1'b1;
    bus.clear = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.clear = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL coll_idle got done=%b busy=%b want 0 0",
               bus.done, bus.busy); end
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL coll_stay got rdy=%b want 0", bus.in_ready); end
    pulse_start();
    checks++;
    if (bus.busy !== 1'b1 || bus.patch_count !== '0) begin errors++;
      $display("FAIL coll_restart got busy=%b cnt=%0d want 1 0",
               bus.busy, bus.patch_count); end
  endtask

  task automatic test_reset_mid_write();
    feed(0, 1, 0);
    clear_q();
    checks++;
    if (bus.csb0 !== 1'b0) begin errors++;
      $display("FAIL rstw_pre got csb=%b want 0", bus.csb0); end
    #2;
    rst = 1'b1;
    #1;
    checks += 6;
    if (bus.csb0 !== 1'b1 || bus.web0 !== 1'b1) begin errors++;
      $display("FAIL rstw_we got csb=%b web=%b want 1 1",
               bus.csb0, bus.web0); end
    if (bus.addr0 !== '0 || bus.wpatch0 !== '0) begin errors++;
      $display("FAIL rstw_bus got a=%0d d=%h want 0 0",
               bus.addr0, bus.wpatch0); end
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL rstw_rdy got %b want 0", bus.in_ready); end
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
      $display("FAIL rstw_flags got busy=%b done=%b want 0 0",
               bus.busy, bus.done); end
    if (bus.patch_count !== '0) begin errors++;
      $display("FAIL rstw_count got %0d want 0", bus.patch_count); end
    tick();
    rst = 1'b0;
    tick();
    if (wr_addr.size() != 0) begin errors++;
      $display("FAIL rstw_nowr got %0d want 0", wr_addr.size()); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_single_patch();
    test_start_ignored();
    test_clear();
    test_stall();
    test_full_frame();
    test_collision();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/query_patch_loader.md
QUERY_PATCH_LOADER -- requirements
Module: query_patch_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, bits per patch sample.
REQ-002 SHALL have parameter PATCH_SIZE, default 5, samples per patch.
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, patch RAM address width.
REQ-004 SHALL have parameter NUM_PATCHES, default 494, patches per frame (26*19), at most 2**ADDR_WIDTH.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, listed first: clk  input  1  clock; rst  input  1  async active-high reset.
REQ-006 SHALL have port start  input  1  pulse that begins a frame load.
REQ-007 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port in_valid  input  1  sample valid.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  sample value.
REQ-010 SHALL have port in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-011 SHALL have port csb0  output  1  RAM chip select, active-low.
REQ-012 SHALL have port web0  output  1  RAM write enable, active-low.
REQ-013 SHALL have port addr0  output  ADDR_WIDTH  RAM write address.
REQ-014 SHALL have port wpatch0  output  DATA_WIDTH*PATCH_SIZE  RAM write patch.
REQ-015 SHALL have port busy  output  1  high in COLLECT or WRITE.
REQ-016 SHALL have port done  output  1  high in DONE.
REQ-017 SHALL have port patch_count  output  ADDR_WIDTH  patches written this frame.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, WRITE, DONE.
REQ-019 SHALL go IDLE->COLLECT or DONE->COLLECT on start, clearing sample index, patch_count and the assembly register.
REQ-020 SHALL ignore start in COLLECT and WRITE.
REQ-021 SHALL drive in_ready high only in COLLECT.
REQ-022 SHALL place the k-th accepted sample of a patch (k=0..PATCH_SIZE-1) at wpatch0 bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-023 SHALL go COLLECT->WRITE on the clock edge that accepts sample PATCH_SIZE-1.
REQ-024 SHALL, in WRITE, drive csb0=0, web0=0, addr0=patch_count and wpatch0=assembled patch for exactly one cycle, all from registers.
REQ-025 SHALL hold csb0=1 and web0=1 in every state other than WRITE.
REQ-026 SHALL increment patch_count at the end of WRITE, then go to DONE if the new count equals NUM_PATCHES, else to COLLECT.
REQ-027 SHALL sustain one patch per PATCH_SIZE+1 cycles when in_valid stays high.
REQ-028 SHALL not advance the sample index on cycles where in_valid is low in COLLECT (stalls of any length allowed).
REQ-029 SHALL, on clear, go to IDLE on the next edge from any state, cancel any pending write (no csb0 low cycle follows), and drop the partial patch.
REQ-030 SHALL give clear priority over start when both are high.
REQ-031 SHALL hold done high in DONE until start or clear.
REQ-032 SHALL hold patch_count at NUM_PATCHES in DONE.

Reset
REQ-033 SHALL, on rst, asynchronously force IDLE, csb0=1, web0=1, addr0=0, wpatch0=0, in_ready=0, busy=0, done=0, patch_count=0, and sample index 0.
REQ-034 SHALL, when rst asserts mid-WRITE, deassert csb0 immediately without waiting for a clock.

Structure
REQ-035 SHALL take the default constants (DATA_WIDTH, PATCH_SIZE, ADDR_WIDTH, NUM_PATCHES) and the FSM state enum from the shared package query_patch_pkg.
REQ-036 SHALL be a single module with no sub-module; the assembly register and counters are implemented inline.

Verification
REQ-037 SHALL cover a single patch: start, then samples 1,2,3,4,5 back-to-back -> one write cycle with addr0=0 and wpatch0={11'd5,11'd4,11'd3,11'd2,11'd1}, patch_count=1.
REQ-038 SHALL cover a full frame: 494*5 samples continuous -> 494 writes at addr0 0..493, one every 6 cycles, then done=1, patch_count=494, in_ready=0.
REQ-039 SHALL cover stalls: in_valid toggled randomly -> written patches identical to the unstalled case, no extra writes.
REQ-040 SHALL cover clear: clear asserted after 3 samples of patch 2 -> IDLE next cycle, no write at addr0=2, and after a new start the first write is at addr0=0.
REQ-041 SHALL cover reset mid-WRITE: rst asserted while csb0=0 -> csb0=1 within the same cycle, and all REQ-033 values hold.
REQ-042 SHALL cover start/clear collision: start and clear high together in DONE -> IDLE and done=0.
